// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one MEMIF port between display read DMA (D),
// camera write (C) and the CPU bus port (P). One 16-bit access at a time,
// display first with a run limit, CPU protected by a starvation counter.
module sdram_port_arbiter #(
    parameter int AW           = 21,
    parameter int D_MAX_RUN    = 8,
    parameter int STARVE_LIMIT = 64,
    parameter int DATA_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              D_REQ,
    input  logic [AW-1:0]     D_ADDR,
    output logic              D_ACK,
    input  logic              C_REQ,
    input  logic [AW-1:0]     C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic              C_ACK,
    input  logic              P_REQ,
    input  logic              P_WE,
    input  logic [AW-1:0]     P_ADDR,
    input  logic [DATA_W-1:0] P_WDATA,
    input  logic [1:0]        P_BE,
    output logic              P_ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              M_REQ,
    output logic              M_WE,
    output logic [AW-1:0]     M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    output logic [1:0]        M_BE,
    input  logic              M_ACK,
    input  logic [DATA_W-1:0] M_RDATA,
    output logic [2:0]        GNT
);

    localparam int RUN_W = $clog2(D_MAX_RUN + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(D_MAX_RUN);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] d_run;
    logic [STV_W-1:0] starve_cnt;
    logic [2:0]       win;
    logic             starve_hit;
    logic             d_block;
    logic             grant_now;

    // starve_hit is gated with P_REQ because the counter clears one cycle late
    assign starve_hit = P_REQ && (starve_cnt >= STV_MAX);
    assign d_block    = (d_run >= RUN_MAX) && (C_REQ || P_REQ);
    assign grant_now  = (state == ST_IDLE) && (win != 3'b000);

    // Priority pick of the next owner; only consumed while IDLE
    always_comb begin
        win = 3'b000;
        if (starve_hit)
            win = 3'b100;
        else if (D_REQ && !d_block)
            win = 3'b001;
        else if (C_REQ)
            win = 3'b010;
        else if (P_REQ)
            win = 3'b100;
        else if (D_REQ)
            win = 3'b001;
    end

    // Display run length: saturating count of D grants, cleared by any other grant
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            d_run <= '0;
        end else if (grant_now) begin
            if (win[0]) begin
                if (d_run < RUN_MAX)
                    d_run <= d_run + 1'b1;
            end else begin
                d_run <= '0;
            end
        end
    end

    // CPU wait counter: counts cycles P waits without owning the port
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_cnt <= '0;
        end else if ((grant_now && win[2]) || !P_REQ) begin
            starve_cnt <= '0;
        end else if (!GNT[2] && (starve_cnt < STV_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Access FSM: latch winner's fields, hold M_REQ until M_ACK, pulse owner's ACK
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            GNT     <= 3'b000;
            M_REQ   <= 1'b0;
            M_WE    <= 1'b0;
            M_ADDR  <= '0;
            M_WDATA <= '0;
            M_BE    <= 2'b00;
            RDATA   <= '0;
            D_ACK   <= 1'b0;
            C_ACK   <= 1'b0;
            P_ACK   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        GNT   <= win;
                        M_REQ <= 1'b1;
                        state <= ST_BUSY;
                        if (win[2]) begin
                            M_WE    <= P_WE;
                            M_ADDR  <= P_ADDR;
                            M_WDATA <= P_WDATA;
                            M_BE    <= P_BE;
                        end else if (win[1]) begin
                            M_WE    <= 1'b1;
                            M_ADDR  <= C_ADDR;
                            M_WDATA <= C_WDATA;
                            M_BE    <= 2'b11;
                        end else begin
                            M_WE    <= 1'b0;
                            M_ADDR  <= D_ADDR;
                            M_WDATA <= '0;
                            M_BE    <= 2'b11;
                        end
                    end
                end
                ST_BUSY: begin
                    if (M_ACK) begin
                        M_REQ <= 1'b0;
                        if (!M_WE)
                            RDATA <= M_RDATA;
                        D_ACK <= GNT[0];
                        C_ACK <= GNT[1];
                        P_ACK <= GNT[2];
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    D_ACK <= 1'b0;
                    C_ACK <= 1'b0;
                    P_ACK <= 1'b0;
                    GNT   <= 3'b000;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
